// File: rtl/sdft_bin_pkg.sv
// Constants and types shared by the sdft bin writer, the waterfall scroller and freq_bram.
// Holds the sequencer state encodings and the log-code field layout.
package sdft_bin_pkg;

    localparam int FREQ_BINS_DEF = 320;
    localparam int ADDR_W_DEF    = 9;

    localparam int LOG_EXP_W = 4;
    localparam int LOG_MAN_W = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_PROCESS = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    // Colour index: octave in the upper nibble, first four fraction bits below it.
    typedef struct packed {
        logic [LOG_EXP_W-1:0] exponent;
        logic [LOG_MAN_W-1:0] mantissa;
    } logCode_t;

endpackage

// File: rtl/log_compress.sv
// Combinational log-scale compressor: leading-one position plus the four bits below it.
// Values 0 and 1 both map to code 0.
module log_compress
    import sdft_bin_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic [BIN_W-1:0]  value_i,
    output logic [DATA_W-1:0] code_o
);

    logic [LOG_EXP_W-1:0] lead;
    logic [BIN_W-1:0]     norm;
    logCode_t             code;

    // Shifting the leading one up to the MSB leaves the mantissa bits right below it, zero-filled.
    always_comb begin
        lead = '0;
        for (int i = 1; i < BIN_W; i++) begin
            if (value_i[i]) begin
                lead = LOG_EXP_W'(i);
            end
        end
        norm          = value_i << (LOG_EXP_W'(BIN_W - 1) - lead);
        code.exponent = lead;
        code.mantissa = norm[BIN_W-2 -: LOG_MAN_W];
        if (value_i <= BIN_W'(1)) begin
            code = '0;
        end
        code_o = DATA_W'(code);
    end

endmodule

// File: rtl/sdft_bin_writer.sv
// Sequencer feeding ADC samples to the sliding DFT and writing log-compressed bins to the BRAM.
// Address-to-write latency is two cycles: sdft register, then the gain/saturate register.
module sdft_bin_writer
    import sdft_bin_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int DATA_W       = 8,
    parameter int BIN_W        = 16,
    parameter int FREQ_BINS    = FREQ_BINS_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [2:0]              gain_i,
    input  logic [SAMPLE_WIDTH-1:0] adc_data_i,
    input  logic                    sdft_ready_i,
    output logic                    sdft_start_o,
    output logic [DATA_W-1:0]       sdft_sample_o,
    output logic                    sdft_read_o,
    output logic [ADDR_W-1:0]       bin_addr_o,
    input  logic [BIN_W-1:0]        bin_out_i,
    output logic                    bram_w_en_o,
    output logic [ADDR_W-1:0]       bram_w_addr_o,
    output logic [DATA_W-1:0]       bram_w_data_o,
    output logic                    frame_done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FREQ_BINS - 1);

    logic [2:0]        state_q,     state_d;
    logic              start_q,     start_d;
    logic [DATA_W-1:0] sample_q,    sample_d;
    logic              read_q,      read_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              rdValid_q,   rdValid_d;
    logic [ADDR_W-1:0] rdAddr_q,    rdAddr_d;
    logic              s1Valid_q,   s1Valid_d;
    logic [ADDR_W-1:0] s1Addr_q,    s1Addr_d;
    logic [BIN_W-1:0]  s1Data_q,    s1Data_d;
    logic              frameDone_q, frameDone_d;

    logic [BIN_W+6:0]  shifted;
    logic [BIN_W-1:0]  saturated;

    // rdValid/rdAddr track the sdft's own output register so tags line up with bin_out.
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        sample_d    = sample_q;
        read_d      = read_q;
        addr_d      = addr_q;
        rdValid_d   = read_q;
        rdAddr_d    = addr_q;

        shifted     = {7'b0, bin_out_i} << gain_i;
        saturated   = (|shifted[BIN_W+6:BIN_W]) ? '1 : shifted[BIN_W-1:0];
        s1Valid_d   = rdValid_q;
        s1Addr_d    = rdAddr_q;
        s1Data_d    = rdValid_q ? saturated : '0;
        frameDone_d = rdValid_q && (rdAddr_q == LAST_ADDR);

        case (state_q)
            ST_IDLE: begin
                if (enable_i && sdft_ready_i) begin
                    sample_d = adc_data_i[SAMPLE_WIDTH-1 -: DATA_W];
                    start_d  = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (!sdft_ready_i) begin
                    start_d = 1'b0;
                    state_d = ST_PROCESS;
                end
            end
            ST_PROCESS: begin
                start_d = 1'b0;
                if (sdft_ready_i) begin
                    read_d  = 1'b1;
                    addr_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (addr_q == LAST_ADDR) begin
                    read_d  = 1'b0;
                    addr_d  = '0;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (frameDone_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                read_d  = 1'b0;
                addr_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            sample_q    <= '0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            rdValid_q   <= 1'b0;
            rdAddr_q    <= '0;
            s1Valid_q   <= 1'b0;
            s1Addr_q    <= '0;
            s1Data_q    <= '0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            sample_q    <= sample_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            rdValid_q   <= rdValid_d;
            rdAddr_q    <= rdAddr_d;
            s1Valid_q   <= s1Valid_d;
            s1Addr_q    <= s1Addr_d;
            s1Data_q    <= s1Data_d;
            frameDone_q <= frameDone_d;
        end
    end

    log_compress #(
        .BIN_W  (BIN_W),
        .DATA_W (DATA_W)
    ) u_logCompress (
        .value_i (s1Data_q),
        .code_o  (bram_w_data_o)
    );

    assign sdft_start_o  = start_q;
    assign sdft_sample_o = sample_q;
    assign sdft_read_o   = read_q;
    assign bin_addr_o    = addr_q;
    assign bram_w_en_o   = s1Valid_q;
    assign bram_w_addr_o = s1Addr_q;
    assign frame_done_o  = frameDone_q;

endmodule

// File: tb/tb_sdft_bin_writer.sv
// Self-checking bench for sdft_bin_writer: behavioural sdft model, write scoreboard,
// table vectors for the log mapping and randomized frames against an arithmetic reference.
module tb_sdft_bin_writer;

    localparam int NBINS = 320;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  gain;
    logic [11:0] adcData;
    logic        sdftReady;
    logic        sdftStart;
    logic [7:0]  sdftSample;
    logic        sdftRead;
    logic [8:0]  binAddr;
    logic [15:0] binOut;
    logic        bramWEn;
    logic [8:0]  bramWAddr;
    logic [7:0]  bramWData;
    logic        frameDone;

    int nChecks = 0;
    int nErrors = 0;

    logic [15:0] binMem [512];
    int          procLat = 20;

    int cyc = 0;
    int wrCount, contigErr, latErr, fdCount, fdWithLast, readCount, maxIssued;
    int startViol, startCycles, readyRiseCyc, readRiseCyc, lastWrCyc, lastWrAddr;
    int wrData   [512];
    int issueCyc [512];

    typedef struct {
        logic [2:0]  g;
        logic [15:0] bin;
        logic [7:0]  code;
    } vec_t;
    vec_t vecs [12];

    sdft_bin_writer dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (enable),
        .gain_i        (gain),
        .adc_data_i    (adcData),
        .sdft_ready_i  (sdftReady),
        .sdft_start_o  (sdftStart),
        .sdft_sample_o (sdftSample),
        .sdft_read_o   (sdftRead),
        .bin_addr_o    (binAddr),
        .bin_out_i     (binOut),
        .bram_w_en_o   (bramWEn),
        .bram_w_addr_o (bramWAddr),
        .bram_w_data_o (bramWData),
        .frame_done_o  (frameDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sdft model: registered bin readout, ready drops the cycle after start and returns procLat cycles later.
    initial begin : sdftModel
        logic [8:0] seenAddr;
        logic       seenStart;
        int         busy;
        busy      = 0;
        sdftReady = 1'b1;
        binOut    = '0;
        forever begin
            @(negedge clk);
            seenAddr  = binAddr;
            seenStart = sdftStart;
            @(posedge clk);
            #1;
            binOut = binMem[seenAddr];
            if (busy > 0) begin
                busy--;
                if (busy == 0) sdftReady = 1'b1;
            end else if (seenStart && sdftReady) begin
                sdftReady = 1'b0;
                busy      = procLat;
            end
        end
    end

    // Scoreboard: records every write, issued address and handshake edge, sampled mid-cycle.
    initial begin : monitor
        logic prevStart, prevReady, prevRead;
        prevStart = 1'b0;
        prevReady = 1'b1;
        prevRead  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sdftStart) startCycles++;
            if (prevStart && !sdftStart && prevReady) startViol++;
            if (!prevReady && sdftReady) readyRiseCyc = cyc;
            if (!prevRead && sdftRead) readRiseCyc = cyc;
            if (sdftRead) begin
                issueCyc[binAddr] = cyc;
                readCount++;
                if (int'(binAddr) > maxIssued) maxIssued = int'(binAddr);
            end
            if (bramWEn) begin
                if (wrCount == 0 && bramWAddr != 9'd0) contigErr++;
                if (wrCount > 0 && (cyc != lastWrCyc + 1 || int'(bramWAddr) != lastWrAddr + 1)) contigErr++;
                if (cyc - issueCyc[bramWAddr] != 2) latErr++;
                wrData[bramWAddr] = int'(bramWData);
                lastWrCyc  = cyc;
                lastWrAddr = int'(bramWAddr);
                wrCount++;
            end
            if (frameDone) begin
                fdCount++;
                if (bramWEn && bramWAddr == 9'(NBINS - 1)) fdWithLast++;
            end
            prevStart = sdftStart;
            prevReady = sdftReady;
            prevRead  = sdftRead;
        end
    end

    function automatic int satRef(input int s, input int g);
        int v;
        v = s * (1 << g);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Colour index from the arithmetic definition: floor(log2 s) and the first 4 binary fraction digits.
    function automatic int logRef(input int s);
        int p;
        if (s <= 1) return 0;
        p = 0;
        while ((s >> (p + 1)) != 0) p++;
        return p * 16 + (((s - (1 << p)) * 16) >> p);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearScoreboard();
        wrCount = 0; contigErr = 0; latErr = 0; fdCount = 0; fdWithLast = 0;
        readCount = 0; maxIssued = -1; startViol = 0; startCycles = 0;
        readyRiseCyc = -100; readRiseCyc = -200; lastWrCyc = -10; lastWrAddr = -10;
        for (int i = 0; i < 512; i++) begin
            wrData[i]   = -1;
            issueCyc[i] = -1000;
        end
    endtask

    task automatic startFrame(input logic [2:0] g, input logic [11:0] adc, input int lat);
        int k;
        clearScoreboard();
        gain    = g;
        adcData = adc;
        procLat = lat;
        enable  = 1'b1;
        k = 0;
        while (!sdftStart && k < 50) begin
            tick();
            k++;
        end
        if (!sdftStart) checkOutput("start timeout", 0, 1);
        enable  = 1'b0;
        adcData = 12'($urandom);
    endtask

    task automatic applyStimulus(input logic [2:0] g, input logic [11:0] adc, input int lat);
        int k;
        logic [11:0] adcCopy;
        adcCopy = adc;
        startFrame(g, adc, lat);
        k = 0;
        while (fdCount == 0 && k < 1000) begin
            tick();
            k++;
        end
        repeat (5) tick();
        checkOutput("sample latch", int'(sdftSample), int'(adcCopy[11:4]));
        checkOutput("frame_done pulses", fdCount, 1);
        checkOutput("frame_done with last write", fdWithLast, 1);
        checkOutput("write count", wrCount, NBINS);
        checkOutput("write order", contigErr, 0);
        checkOutput("write latency", latErr, 0);
        checkOutput("issued addresses", readCount, NBINS);
        checkOutput("max issued address", maxIssued, NBINS - 1);
        checkOutput("start dropped early", startViol, 0);
        checkOutput("read after ready", readRiseCyc - readyRiseCyc, 1);
        checkOutput("idle read", int'(sdftRead), 0);
        checkOutput("idle start", int'(sdftStart), 0);
        for (int a = 0; a < NBINS; a++) begin
            checkOutput($sformatf("data[%0d] g=%0d bin=%0h", a, g, binMem[a]),
                        wrData[a], logRef(satRef(int'(binMem[a]), int'(g))));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " start"},  int'(sdftStart),  0);
        checkOutput({tag, " sample"}, int'(sdftSample), 0);
        checkOutput({tag, " read"},   int'(sdftRead),   0);
        checkOutput({tag, " addr"},   int'(binAddr),    0);
        checkOutput({tag, " w_en"},   int'(bramWEn),    0);
        checkOutput({tag, " w_addr"}, int'(bramWAddr),  0);
        checkOutput({tag, " w_data"}, int'(bramWData),  0);
        checkOutput({tag, " done"},   int'(frameDone),  0);
    endtask

    initial begin : main
        int k;
        logic [2:0] gains [6];
        for (int i = 0; i < 512; i++) binMem[i] = '0;
        reset   = 1'b1;
        enable  = 1'b0;
        gain    = '0;
        adcData = '0;
        clearScoreboard();

        vecs[0]  = '{3'd0, 16'h0000, 8'h00};
        vecs[1]  = '{3'd0, 16'h0001, 8'h00};
        vecs[2]  = '{3'd0, 16'h0003, 8'h18};
        vecs[3]  = '{3'd0, 16'h0100, 8'h80};
        vecs[4]  = '{3'd0, 16'hFFFF, 8'hFF};
        vecs[5]  = '{3'd0, 16'h0002, 8'h10};
        vecs[6]  = '{3'd0, 16'h8000, 8'hF0};
        vecs[7]  = '{3'd1, 16'h0100, 8'h90};
        vecs[8]  = '{3'd2, 16'h4000, 8'hFF};
        vecs[9]  = '{3'd3, 16'h0005, 8'h54};
        vecs[10] = '{3'd4, 16'h0123, 8'hC2};
        vecs[11] = '{3'd7, 16'h01FF, 8'hFF};
        gains = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

        repeat (3) tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // One frame per gain: table vectors sit at their own bins, the rest is random.
        for (int gi = 0; gi < 6; gi++) begin
            for (int a = 0; a < NBINS; a++) binMem[a] = 16'($urandom >> ($urandom_range(0, 16)));
            for (int v = 0; v < 12; v++) begin
                if (vecs[v].g == gains[gi]) binMem[v] = vecs[v].bin;
            end
            if (gi == 0) applyStimulus(gains[gi], 12'hABC, 20);
            else applyStimulus(gains[gi], 12'($urandom), $urandom_range(3, 30));
            for (int v = 0; v < 12; v++) begin
                if (vecs[v].g == gains[gi]) begin
                    checkOutput($sformatf("vector %0d code", v), wrData[v], int'(vecs[v].code));
                end
            end
        end

        for (int a = 0; a < NBINS; a++) binMem[a] = 16'($urandom);
        applyStimulus(3'($urandom), 12'($urandom), $urandom_range(1, 40));

        // Reset mid-sweep: outputs clear next cycle, sweep abandoned, fresh frame afterwards.
        startFrame(3'd1, 12'h5A3, 10);
        k = 0;
        while (!(sdftRead && binAddr == 9'd150) && k < 500) begin
            tick();
            k++;
        end
        checkOutput("reached addr 150", int'(sdftRead && binAddr == 9'd150), 1);
        reset = 1'b1;
        tick();
        checkAllZero("mid reset");
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        checkOutput("no done after reset", fdCount, 0);
        checkOutput("writes stopped at reset", int'(wrCount <= 151), 1);
        applyStimulus(3'd2, 12'h3C7, 15);

        // enable low in IDLE with ready high: nothing may happen.
        clearScoreboard();
        enable = 1'b0;
        repeat (100) tick();
        checkOutput("idle start cycles", startCycles, 0);
        checkOutput("idle writes", wrCount, 0);
        checkOutput("idle ready", int'(sdftReady), 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
